// File: rtl/note_recorder.sv
// note_recorder: records the live note selected on sw as (note, duration)
// entries in an on-chip buffer and replays them on request. note_out
// drives the frequency generator's note select.
//
// Ports:
//   CLK       system clock
//   RESET     asynchronous active-high reset; clears all state
//   sw        debounced note switches, bit7 = C4 ... bit0 = C5
//   rec_btn   one-cycle pulse, starts/stops recording
//   play_btn  one-cycle pulse, starts/stops playback
//   note_out  0 = rest, 1 = C4 ... 8 = C5
//   recording high while recording
//   playing   high while playing back
//   count     number of valid buffer entries
//   full      high when count == DEPTH
//
// Build option: define NOTE_RECORDER_LOOP_EN to make playback wrap from
// the last entry back to entry 0 instead of returning to idle.
module note_recorder #(
  parameter int DEPTH    = 32,
  parameter int TICK_DIV = 250000,
  parameter int DUR_W    = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [7:0]             sw,
  input  logic                   rec_btn,
  input  logic                   play_btn,
  output logic [3:0]             note_out,
  output logic                   recording,
  output logic                   playing,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] DUR_MAX  = '1;
  localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    PLAY = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0]       enc;
  logic [3:0]       live;
  logic [DIV_W-1:0] div;
  logic             tick;
  logic             btn;

  logic [3:0]       seg_note;
  logic [DUR_W-1:0] seg_dur;
  logic             seg_close;
  logic [DUR_W-1:0] wr_dur;

  logic [3:0]       mem_note [DEPTH];
  logic [DUR_W-1:0] mem_dur  [DEPTH];

  logic [AW-1:0]    idx;
  logic [AW-1:0]    ld_idx;
  logic [DUR_W-1:0] rem;
  logic [3:0]       play_note;
  logic             last;
  logic             expire;

  // Ascending scan so the highest set switch wins.
  always_comb begin
    enc = '0;
    for (int unsigned k = 0; k < 8; k++)
      if (sw[k]) enc = 4'(8 - k);
  end

  assign tick      = (div == DIV_LAST);
  assign btn       = rec_btn | play_btn;
  assign seg_close = btn || (live != seg_note) || (tick && (seg_dur == DUR_MAX));
  assign wr_dur    = (seg_dur == '0) ? DUR_ONE : seg_dur;
  assign last      = ({1'b0, idx} == (count - 1'b1));
  assign expire    = tick && (rem == DUR_ONE);
  // Wrapping to 0 on the last entry only matters in loop mode; otherwise
  // the FSM leaves PLAY on that edge and the reload is never observed.
  assign ld_idx    = last ? '0 : idx + 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rec_btn)
          state_nxt = REC;
        else if (play_btn && (count != '0))
          state_nxt = PLAY;
      end
      REC: begin
        if (seg_close && (btn || (count == CNT_LAST)))
          state_nxt = IDLE;
      end
      PLAY: begin
        if (btn)
          state_nxt = IDLE;
        else if (expire && last) begin
`ifdef NOTE_RECORDER_LOOP_EN
          state_nxt = PLAY;
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign note_out  = (state == PLAY) ? play_note : live;
  assign recording = (state == REC);
  assign playing   = (state == PLAY);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      live      <= '0;
      div       <= '0;
      seg_note  <= '0;
      seg_dur   <= '0;
      count     <= '0;
      full      <= 1'b0;
      idx       <= '0;
      rem       <= '0;
      play_note <= '0;
    end else begin
      state <= state_nxt;
      live  <= enc;
      div   <= tick ? '0 : div + 1'b1;
      case (state)
        IDLE: begin
          if (rec_btn) begin
            count    <= '0;
            full     <= 1'b0;
            div      <= '0;
            seg_note <= live;
            seg_dur  <= '0;
          end else if (play_btn && (count != '0)) begin
            idx       <= '0;
            play_note <= mem_note[0];
            rem       <= mem_dur[0];
            div       <= '0;
          end
        end
        REC: begin
          if (seg_close) begin
            count    <= count + 1'b1;
            full     <= (count == CNT_LAST);
            seg_note <= live;
            seg_dur  <= '0;
          end else if (tick) begin
            seg_dur <= seg_dur + 1'b1;
          end
        end
        PLAY: begin
          if (!btn) begin
            if (expire) begin
              idx       <= ld_idx;
              play_note <= mem_note[ld_idx];
              rem       <= mem_dur[ld_idx];
              div       <= '0;
            end else if (tick) begin
              rem <= rem - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer has no reset; its contents are only meaningful below count.
  always_ff @(posedge CLK) begin
    if ((state == REC) && seg_close) begin
      mem_note[count[AW-1:0]] <= seg_note;
      mem_dur[count[AW-1:0]]  <= wr_dur;
    end
  end

endmodule

// File: tb/tb_note_recorder.sv
module tb_note_recorder;

  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 4;
  localparam int DUR_W    = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       rec_btn;
  logic       play_btn;
  logic [3:0] note_out;
  logic       recording;
  logic       playing;
  logic [2:0] count;
  logic       full;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] note;
    int         dur;
  } ent_t;

  typedef struct {
    logic [3:0] note;
    logic       act;
  } cyc_t;

  ent_t ent_q[$];
  cyc_t exp_q[$];

  note_recorder #(
    .DEPTH   (DEPTH),
    .TICK_DIV(TICK_DIV),
    .DUR_W   (DUR_W)
  ) dut (
    .CLK      (clk),
    .RESET    (rst),
    .sw       (sw),
    .rec_btn  (rec_btn),
    .play_btn (play_btn),
    .note_out (note_out),
    .recording(recording),
    .playing  (playing),
    .count    (count),
    .full     (full)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_rec();
    rec_btn = 1'b1;
    cyc(1);
    rec_btn = 1'b0;
  endtask

  task automatic pulse_play();
    play_btn = 1'b1;
    cyc(1);
    play_btn = 1'b0;
  endtask

  task automatic add_ent(input logic [3:0] note, input int dur);
    ent_t e;
    e.note = note;
    e.dur  = dur;
    ent_q.push_back(e);
  endtask

  // Expand the expected entries into a per-cycle note/playing sequence,
  // then play back and compare cycle by cycle.
  task automatic play_check(input logic [3:0] live_now);
    cyc_t e;
    exp_q.delete();
    foreach (ent_q[i])
      repeat (ent_q[i].dur * TICK_DIV) exp_q.push_back('{ent_q[i].note, 1'b1});
`ifdef NOTE_RECORDER_LOOP_EN
    exp_q.push_back('{ent_q[0].note, 1'b1});
`else
    exp_q.push_back('{live_now, 1'b0});
`endif
    pulse_play();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("play_note", {28'd0, note_out}, {28'd0, e.note});
      chk("play_flag", {31'd0, playing}, {31'd0, e.act});
      if (exp_q.size() > 0) cyc(1);
    end
`ifdef NOTE_RECORDER_LOOP_EN
    pulse_play();
    chk("loop_stop_flag", {31'd0, playing}, 32'd0);
    chk("loop_stop_note", {28'd0, note_out}, {28'd0, live_now});
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    sw       = 8'h20;
    rec_btn  = 1'b0;
    play_btn = 1'b0;
    cyc(3);
    chk("rst_note",  {28'd0, note_out},  32'd0);
    chk("rst_rec",   {31'd0, recording}, 32'd0);
    chk("rst_play",  {31'd0, playing},   32'd0);
    chk("rst_count", {29'd0, count},     32'd0);
    chk("rst_full",  {31'd0, full},      32'd0);
    rst = 1'b0;
    chk("rel_note0", {28'd0, note_out}, 32'd0);
    cyc(1);
    chk("rel_note", {28'd0, note_out},  32'd3);
    chk("rel_rec",  {31'd0, recording}, 32'd0);

    // play with empty buffer stays idle; rec+play together records
    pulse_play();
    chk("empty_play", {31'd0, playing},   32'd0);
    chk("empty_rec",  {31'd0, recording}, 32'd0);
    rec_btn  = 1'b1;
    play_btn = 1'b1;
    cyc(1);
    rec_btn  = 1'b0;
    play_btn = 1'b0;
    chk("prio_rec",   {31'd0, recording}, 32'd1);
    chk("prio_play",  {31'd0, playing},   32'd0);
    chk("prio_count", {29'd0, count},     32'd0);
    pulse_rec();
    chk("prio_stop_rec",   {31'd0, recording}, 32'd0);
    chk("prio_stop_count", {29'd0, count},     32'd1);

    // basic record: C4 for 12 cycles, rest for 8
    sw = 8'h80;
    cyc(2);
    ent_q.delete();
    pulse_rec();
    chk("rec_on",    {31'd0, recording}, 32'd1);
    chk("rec_count", {29'd0, count},     32'd0);
    cyc(12);
    sw = 8'h00;
    add_ent(4'd1, 3);
    cyc(2);
    chk("rec_first_write", {29'd0, count}, 32'd1);
    cyc(6);
    pulse_rec();
    add_ent(4'd0, 2);
    chk("rec_stop_count", {29'd0, count},     32'd2);
    chk("rec_stop_rec",   {31'd0, recording}, 32'd0);
    play_check(4'd0);

    // fill the buffer: four writes then auto-stop, fifth note dropped
    sw = 8'h40;
    cyc(2);
    ent_q.delete();
    pulse_rec();
    chk("full_clr", {31'd0, full}, 32'd0);
    sw = 8'h20; add_ent(4'd2, 1); cyc(4);
    sw = 8'h10; add_ent(4'd3, 1); cyc(4);
    sw = 8'h08; add_ent(4'd4, 1); cyc(4);
    sw = 8'h04; add_ent(4'd5, 1); cyc(1);
    chk("full_pre_count", {29'd0, count},     32'd3);
    chk("full_pre_rec",   {31'd0, recording}, 32'd1);
    cyc(1);
    chk("full_count", {29'd0, count},     32'd4);
    chk("full_flag",  {31'd0, full},      32'd1);
    chk("full_rec",   {31'd0, recording}, 32'd0);
    cyc(3);
    play_check(4'd6);
    chk("full_persist", {31'd0, full}, 32'd1);

    // duration saturation at 15 ticks
    sw = 8'h01;
    cyc(2);
    ent_q.delete();
    pulse_rec();
    chk("sat_full",  {31'd0, full},  32'd0);
    chk("sat_count", {29'd0, count}, 32'd0);
    cyc(63);
    chk("sat_pre_count", {29'd0, count}, 32'd0);
    cyc(1);
    add_ent(4'd8, 15);
    chk("sat_count1", {29'd0, count},     32'd1);
    chk("sat_rec",    {31'd0, recording}, 32'd1);
    cyc(5);
    pulse_rec();
    add_ent(4'd8, 1);
    chk("sat_count2",  {29'd0, count},     32'd2);
    chk("sat_rec_off", {31'd0, recording}, 32'd0);
    play_check(4'd8);

    // aborts
    sw = 8'h80;
    cyc(2);
    pulse_play();
    chk("abort_play_on", {31'd0, playing},  32'd1);
    chk("abort_note0",   {28'd0, note_out}, 32'd8);
    cyc(5);
    pulse_play();
    chk("abort_play_off", {31'd0, playing},   32'd0);
    chk("abort_live",     {28'd0, note_out},  32'd1);
    chk("abort_rec",      {31'd0, recording}, 32'd0);
    pulse_play();
    cyc(3);
    pulse_rec();
    chk("abort_rb_play",  {31'd0, playing},   32'd0);
    chk("abort_rb_rec",   {31'd0, recording}, 32'd0);
    chk("abort_rb_count", {29'd0, count},     32'd2);
    play_check(4'd1);

    // reset during recording
    pulse_rec();
    cyc(6);
    rst = 1'b1;
    #1;
    chk("mid_rst_count", {29'd0, count},     32'd0);
    chk("mid_rst_rec",   {31'd0, recording}, 32'd0);
    chk("mid_rst_note",  {28'd0, note_out},  32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("post_rst_note", {28'd0, note_out}, 32'd1);
    chk("post_rst_rec",  {31'd0, recording}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
